spinner_multi: RTL

SPINNER_MULTI -- requirements
Module: spinner_multi

---
 rtl/spinner_pkg.sv | 32 +++
 rtl/spinner_chan.sv | 145 ++++++++++++++
 rtl/spinner_multi.sv | 78 +++++++
 3 files changed

// File: rtl/spinner_pkg.sv
// Shared types and width helpers for the multi-channel spinner.
package spinner_pkg;

  // Acceleration state, derived from the accel counter of a channel.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_CRUISE = 2'd2
  } accel_state_e;

  // Direction of the last single-direction button press.
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // Accumulator width: output bits plus fractional bits below them.
  function automatic int acc_width(input int out_w, input int frac_w);
    return out_w + frac_w;
  endfunction

  // Signed width for delta and sum arithmetic. It must hold the accumulator
  // with two bits of headroom, and also the largest spinner product
  // (8-bit signed delta times the multiplier), plus one guard bit.
  function automatic int sum_width(input int acc_w, input int inc_spinner);
    int spin_w;
    spin_w = 9 + $clog2(inc_spinner + 1);
    return ((acc_w + 2 > spin_w) ? acc_w + 2 : spin_w) + 1;
  endfunction

endpackage

// File: rtl/spinner_chan.sv
// One spinner channel: button/accel handling, spinner delta, accumulator.
//
// Handshake note: there is no valid/ready flow here. strobe_edge is a
// single-cycle qualifier from the top level; spin_in[8] toggling marks a new
// spinner sample. Both are consumed in the cycle they occur and the result is
// registered at the next rising edge.
module spinner_chan
  import spinner_pkg::*;
#(
  parameter int OUT_W       = 8,
  parameter int FRAC_W      = 2,
  parameter int INC_NORMAL  = 20,
  parameter int INC_FAST    = 27,
  parameter int INC_SPINNER = 20,
  parameter int ACCEL_STEP  = 2,
  parameter int ACCEL_MAX   = 8,
  parameter int CLAMP       = 0,
  localparam int ACC_W      = acc_width(OUT_W, FRAC_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe_edge,
  input  logic             minus,
  input  logic             plus,
  input  logic             fast,
  input  logic [8:0]       spin_in,
  output logic [ACC_W-1:0] acc_o,
  output logic             moving_o,
  output accel_state_e     state_o
);

  localparam int SUM_W   = sum_width(ACC_W, INC_SPINNER);
  localparam int ACCEL_W = (ACCEL_MAX < 1) ? 1 : $clog2(ACCEL_MAX + 1);

  localparam logic signed [SUM_W-1:0] NORMAL_S = SUM_W'(INC_NORMAL);
  localparam logic signed [SUM_W-1:0] FAST_S   = SUM_W'(INC_FAST);
  localparam logic signed [SUM_W-1:0] SPIN_S   = SUM_W'(INC_SPINNER);
  localparam logic signed [SUM_W-1:0] STEP_S   = SUM_W'(ACCEL_STEP);
  localparam logic signed [SUM_W-1:0] AMAX_S   = SUM_W'(ACCEL_MAX);
  localparam logic signed [SUM_W-1:0] ACCMAX_S = SUM_W'((1 << ACC_W) - 1);
  localparam logic [ACCEL_W-1:0]      AMAX_A   = ACCEL_W'(ACCEL_MAX);

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACCEL_W-1:0] accel_q, accel_d;
  dir_e               dir_q, dir_d;
  accel_state_e       state_q, state_d;
  logic               sp_r_q, sp_r_d;
  logic               moving_q, moving_d;

  logic                    press_up, press_dn;
  dir_e                    new_dir;
  logic [ACCEL_W-1:0]      accel_use;
  logic signed [SUM_W-1:0] accel_next;
  logic signed [SUM_W-1:0] mag;
  logic signed [SUM_W-1:0] btn_delta;
  logic signed [SUM_W-1:0] spin_ext;
  logic signed [SUM_W-1:0] spin_delta;
  logic signed [SUM_W-1:0] sum;

  // Button delta and acceleration bookkeeping on a strobe edge.
  always_comb begin
    press_up   = plus & ~minus;
    press_dn   = minus & ~plus;
    new_dir    = press_up ? DIR_UP : DIR_DOWN;
    accel_use  = '0;
    accel_next = '0;
    mag        = '0;
    btn_delta  = '0;
    accel_d    = accel_q;
    dir_d      = dir_q;
    if (strobe_edge) begin
      if (press_up || press_dn) begin
        // A fresh press or a continued press uses the current accel and
        // advances it; a reversal restarts from zero for this edge.
        if (dir_q == DIR_NONE || dir_q == new_dir) begin
          accel_use  = accel_q;
          accel_next = $signed({{(SUM_W-ACCEL_W){1'b0}}, accel_q}) + STEP_S;
          accel_d    = (accel_next >= AMAX_S) ? AMAX_A : accel_next[ACCEL_W-1:0];
        end else begin
          accel_use = '0;
          accel_d   = '0;
        end
        dir_d     = new_dir;
        mag       = (fast ? FAST_S : NORMAL_S)
                  + $signed({{(SUM_W-ACCEL_W){1'b0}}, accel_use});
        btn_delta = press_up ? mag : -mag;
      end else begin
        // Release or both buttons: drop back to idle.
        accel_d = '0;
        dir_d   = DIR_NONE;
      end
    end
  end

  // Spinner delta, summed with the button delta and wrapped or saturated.
  always_comb begin
    sp_r_d     = spin_in[8];
    spin_ext   = {{(SUM_W-8){spin_in[7]}}, spin_in[7:0]};
    spin_delta = (spin_in[8] ^ sp_r_q) ? spin_ext * SPIN_S : '0;
    sum        = $signed({{(SUM_W-ACC_W){1'b0}}, acc_q}) + btn_delta + spin_delta;
    acc_d      = sum[ACC_W-1:0];
    if (CLAMP != 0) begin
      if (sum < 0) begin
        acc_d = '0;
      end else if (sum > ACCMAX_S) begin
        acc_d = '1;
      end
    end
    moving_d = (acc_d != acc_q);
  end

  // Accel state follows the accel counter value after this edge.
  always_comb begin
    state_d = ST_RAMP;
    if (accel_d == '0) begin
      state_d = ST_IDLE;
    end else if (accel_d == AMAX_A) begin
      state_d = ST_CRUISE;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      accel_q  <= '0;
      dir_q    <= DIR_NONE;
      state_q  <= ST_IDLE;
      sp_r_q   <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      accel_q  <= accel_d;
      dir_q    <= dir_d;
      state_q  <= state_d;
      sp_r_q   <= sp_r_d;
      moving_q <= moving_d;
    end
  end

  assign acc_o    = acc_q;
  assign moving_o = moving_q;
  assign state_o  = state_q;

endmodule

// File: rtl/spinner_multi.sv
// Multi-channel spinner: shared strobe edge detect plus independent channels.
module spinner_multi
  import spinner_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int OUT_W       = 8,
  parameter int FRAC_W      = 2,
  parameter int INC_NORMAL  = 20,
  parameter int INC_FAST    = 27,
  parameter int INC_SPINNER = 20,
  parameter int ACCEL_STEP  = 2,
  parameter int ACCEL_MAX   = 8,
  parameter int CLAMP       = 0,
  localparam int ACC_W      = acc_width(OUT_W, FRAC_W)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      strobe,
  input  logic [CHANNELS-1:0]       minus,
  input  logic [CHANNELS-1:0]       plus,
  input  logic [CHANNELS-1:0]       fast,
  input  logic [9*CHANNELS-1:0]     spin_in,
  output logic [OUT_W*CHANNELS-1:0] spin_out,
  output logic [CHANNELS-1:0]       moving,
  output logic [ACC_W*CHANNELS-1:0] dbg_acc,
  output logic [2*CHANNELS-1:0]     dbg_state
);

  logic strobe_r_q, strobe_r_d;
  logic strobe_edge;

  // Rising-edge detect of the shared strobe.
  always_comb begin
    strobe_r_d  = strobe;
    strobe_edge = strobe & ~strobe_r_q;
  end

  // Strobe history register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_r_q <= 1'b0;
    end else begin
      strobe_r_q <= strobe_r_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [ACC_W-1:0] acc;
    accel_state_e     st;

    spinner_chan #(
      .OUT_W      (OUT_W),
      .FRAC_W     (FRAC_W),
      .INC_NORMAL (INC_NORMAL),
      .INC_FAST   (INC_FAST),
      .INC_SPINNER(INC_SPINNER),
      .ACCEL_STEP (ACCEL_STEP),
      .ACCEL_MAX  (ACCEL_MAX),
      .CLAMP      (CLAMP)
    ) u_chan (
      .clk        (clk),
      .rst_n      (reset_n),
      .strobe_edge(strobe_edge),
      .minus      (minus[g]),
      .plus       (plus[g]),
      .fast       (fast[g]),
      .spin_in    (spin_in[9*g +: 9]),
      .acc_o      (acc),
      .moving_o   (moving[g]),
      .state_o    (st)
    );

    assign spin_out[OUT_W*g +: OUT_W]  = acc[ACC_W-1:FRAC_W];
    assign dbg_acc[ACC_W*g +: ACC_W]   = acc;
    assign dbg_state[2*g +: 2]         = st;
  end

endmodule
